mux16_rr_arbiter: RTL and testbench



---
 rtl/mux16_rr_arbiter_pkg.sv | 33 +++
 rtl/mux16_rr_arbiter_mux16.sv | 12 +
 rtl/mux16_rr_arbiter.sv | 93 +++++++++
 tb/tb_mux16_rr_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared types and the rotating-priority pick used by the 16-way round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // First set request scanning ptr, ptr+1, ... with 4-bit wrap.
    function automatic pick_t rr_pick16(input logic [NUM_REQ-1:0] req,
                                        input logic [SEL_W-1:0]   ptr);
        pick_t            res;
        logic [SEL_W-1:0] cand;
        res = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ptr + SEL_W'(i);
            if (!res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux16_rr_arbiter_mux16.sv
// 16:1 datapath multiplexer; slice i of data is selected when sel == i.
module mux16 #(
    parameter int N = 4
) (
    input  logic [16*N-1:0] data,
    input  logic [3:0]      sel,
    output logic [N-1:0]    y
);

    assign y = data[sel*N +: N];

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel among 16 requesters,
// locking each grant for up to MAX_BURST beats with an IDLE bubble between grants.
module mux16_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   in_valid,
    input  logic [NUM_REQ*N-1:0] in_data,
    output logic [NUM_REQ-1:0]   in_ready,
    output logic                 out_valid,
    output logic [N-1:0]         out_data,
    input  logic                 out_ready,
    output logic [SEL_W-1:0]     out_select,
    output logic                 busy
);

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    arb_state_t       state, state_nx;
    logic [SEL_W-1:0] sel_nx;
    logic [SEL_W-1:0] rr_ptr, rr_ptr_nx;
    logic [7:0]       beat_cnt, beat_cnt_nx;
    logic             hs;
    pick_t            pick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_select <= '0;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nx;
            out_select <= sel_nx;
            rr_ptr     <= rr_ptr_nx;
            beat_cnt   <= beat_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        sel_nx      = out_select;
        rr_ptr_nx   = rr_ptr;
        beat_cnt_nx = beat_cnt;
        out_valid   = 1'b0;
        busy        = 1'b0;
        hs          = 1'b0;
        in_ready    = '0;
        pick        = rr_pick16(in_valid, rr_ptr);

        case (state)
            IDLE: begin
                if (pick.found) begin
                    sel_nx      = pick.idx;
                    beat_cnt_nx = '0;
                    state_nx    = GRANT;
                end
            end
            GRANT: begin
                busy      = 1'b1;
                out_valid = in_valid[out_select];
                hs        = out_valid & out_ready;
                in_ready  = NUM_REQ'(hs) << out_select;
                if (hs) begin
                    if (beat_cnt == BURST_LAST) begin
                        beat_cnt_nx = '0;
                        rr_ptr_nx   = out_select + SEL_W'(1);
                        state_nx    = IDLE;
                    end else begin
                        beat_cnt_nx = beat_cnt + 8'd1;
                    end
                end else if (!out_valid) begin
                    // Requester withdrew or finished early: give up the slot.
                    beat_cnt_nx = '0;
                    rr_ptr_nx   = out_select + SEL_W'(1);
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    mux16 #(.N(N)) u_mux (
        .data (in_data),
        .sel  (out_select),
        .y    (out_data)
    );

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter: burst lock, rotation, wrap, stall, withdrawal, reset.
module tb_mux16_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_valid, in_valid1;
    logic [63:0] in_data;
    logic [15:0] in_ready, in_ready1;
    logic        out_valid, out_valid1;
    logic [3:0]  out_data, out_data1;
    logic        out_ready, out_ready1;
    logic [3:0]  out_select, out_select1;
    logic        busy, busy1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mux16_rr_arbiter #(.N(4), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .out_select(out_select), .busy(busy)
    );

    mux16_rr_arbiter #(.N(4), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_data(in_data),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_ready(out_ready1), .out_select(out_select1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = '0;
        in_valid1  = '0;
        out_ready  = 1'b1;
        out_ready1 = 1'b1;
        for (int i = 0; i < 16; i++) in_data[i*4 +: 4] = 4'(i);

        #12;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sel", 32'(out_select), 0);
        chk("rst_data", 32'(out_data), 0);
        rst_n = 1'b1;

        // Single requester 5: 1-cycle latency, 4-beat burst, bubble, re-grant
        nxt();
        in_valid = 16'h0020;
        smp();
        chk("t1_latency_idle", 32'(out_valid), 0);
        for (int k = 0; k < 4; k++) begin
            nxt();
            smp();
            chk("t1_ready5", 32'(in_ready), 32'h0020);
            if (k == 0) begin
                chk("t1_valid", 32'(out_valid), 1);
                chk("t1_sel", 32'(out_select), 5);
                chk("t1_data", 32'(out_data), 5);
            end
        end
        nxt();
        smp();
        chk("t1_bubble_valid", 32'(out_valid), 0);
        chk("t1_bubble_busy", 32'(busy), 0);
        nxt();
        smp();
        chk("t1_regrant_sel", 32'(out_select), 5);
        chk("t1_regrant_valid", 32'(out_valid), 1);
        in_valid = '0;

        // Stall on requester 7 for 5 cycles; beat count must not advance
        nxt();
        in_valid  = 16'h0080;
        out_ready = 1'b0;
        smp();
        chk("t4_idle", 32'(busy), 0);
        nxt();
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("t4_stall_valid", 32'(out_valid), 1);
            chk("t4_stall_data", 32'(out_data), 7);
            chk("t4_stall_ready", 32'(in_ready), 0);
            nxt();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("t4_beat_ready7", 32'(in_ready), 32'h0080);
            nxt();
        end
        smp();
        chk("t4_burst_end", 32'(out_valid), 0);

        // Serve 13 briefly so rr_ptr becomes 14, then 15 before 3
        in_valid = 16'h2000;
        nxt();
        smp();
        chk("t3_sel13", 32'(out_select), 13);
        in_valid = 16'h8008;
        nxt();
        smp();
        chk("t3_idle", 32'(busy), 0);
        nxt();
        smp();
        chk("t3_first15", 32'(out_select), 15);
        in_valid = 16'h0008;
        nxt();
        nxt();
        smp();
        chk("t3_then3", 32'(out_select), 3);

        // Requester 2 drops after 2 beats; next search starts from 3
        in_valid = 16'h0004;
        nxt();
        nxt();
        smp();
        chk("t5_sel2", 32'(out_select), 2);
        chk("t5_ready2", 32'(in_ready), 32'h0004);
        nxt();
        smp();
        chk("t5_ready2_b2", 32'(in_ready), 32'h0004);
        nxt();
        in_valid = 16'h0012;
        smp();
        chk("t5_drop_valid", 32'(out_valid), 0);
        chk("t5_drop_ready", 32'(in_ready), 0);
        nxt();
        smp();
        chk("t5_idle", 32'(busy), 0);
        nxt();
        smp();
        chk("t5_next_from3", 32'(out_select), 4);

        // Reset mid-burst on requester 9
        in_valid = 16'h0200;
        nxt();
        nxt();
        smp();
        chk("t6_sel9", 32'(out_select), 9);
        nxt();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_ready", 32'(in_ready), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        smp();
        rst_n    = 1'b1;
        in_valid = 16'h0202;
        nxt();
        smp();
        chk("t6_restart_sel", 32'(out_select), 1);
        in_valid = '0;

        // MAX_BURST=1 instance, all requesting: 0..15,0 with bubbles
        nxt();
        in_valid1 = 16'hFFFF;
        for (int g = 0; g < 17; g++) begin
            nxt();
            smp();
            chk("t2_busy", 32'(busy1), 1);
            chk("t2_sel", 32'(out_select1), 32'(g % 16));
            chk("t2_data", 32'(out_data1), 32'(g % 16));
            nxt();
            smp();
            chk("t2_bubble", 32'(busy1), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
